// File: rtl/vcache_stat_print_pkg.sv
// Shared types for the vcache print-stat controller.
package vcache_stat_print_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PULSE = 2'd1,
      GAP   = 2'd2
   } print_state_e;

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small one-read/one-write FIFO; wrap-bit pointers distinguish full from empty.
module bsg_fifo_1r1w_small #(
   parameter int width_p = 32,
   parameter int els_p   = 4
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               v_i,
   input  logic [width_p-1:0] data_i,
   output logic               ready_o,
   output logic               v_o,
   output logic [width_p-1:0] data_o,
   input  logic               yumi_i
);

   localparam int ptr_w = $clog2(els_p);

   logic [ptr_w:0]     wr_ptr_r, rd_ptr_r;
   logic [width_p-1:0] mem_r [els_p];
   logic               full, empty, enq, deq;

   assign empty   = (wr_ptr_r == rd_ptr_r);
   assign full    = (wr_ptr_r[ptr_w] != rd_ptr_r[ptr_w])
                 && (wr_ptr_r[ptr_w-1:0] == rd_ptr_r[ptr_w-1:0]);
   assign ready_o = ~full;
   assign v_o     = ~empty;
   assign enq     = v_i & ~full;
   assign deq     = yumi_i & ~empty;
   assign data_o  = mem_r[rd_ptr_r[ptr_w-1:0]];

   // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
      end else begin
         if (enq) wr_ptr_r <= wr_ptr_r + 1'b1;
         if (deq) rd_ptr_r <= rd_ptr_r + 1'b1;
      end
   end

   // NOTE: storage is not reset; the pointers alone define which entries are valid.
   always_ff @(posedge clk_i) begin
      if (enq) mem_r[wr_ptr_r[ptr_w-1:0]] <= data_i;
   end

endmodule

// File: rtl/vcache_stat_print_ctrl.sv
// Global cycle counter plus print-stat pulse generator shared by all vcache profilers.
// Queued requests leave as single-cycle pulses spaced by a fixed idle gap.
module vcache_stat_print_ctrl
   import vcache_stat_print_pkg::*;
#(
   parameter int data_width_p = 32,
   parameter int ctr_width_p  = 32,
   parameter int fifo_els_p   = 4,
   parameter int gap_cycles_p = 2
) (
   input  logic                              clk_i,
   input  logic                              reset_i,
   input  logic                              req_v_i,
   input  logic [data_width_p-1:0]           req_tag_i,
   output logic                              req_ready_o,
   output logic [ctr_width_p-1:0]            global_ctr_o,
   output logic                              print_stat_v_o,
   output logic [data_width_p-1:0]           print_stat_tag_o,
   output logic [$clog2(fifo_els_p+1)-1:0]   pending_o
);

   localparam int gap_w = $clog2(gap_cycles_p + 1);

   print_state_e            state_r, state_n;
   logic [gap_w-1:0]        gap_r;
   logic                    fifo_v, enq, deq, gap_load, v_n;
   logic [data_width_p-1:0] fifo_data;

   assign enq = req_v_i & req_ready_o;

   bsg_fifo_1r1w_small #(
      .width_p (data_width_p),
      .els_p   (fifo_els_p)
   ) tag_fifo (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .v_i     (req_v_i),
      .data_i  (req_tag_i),
      .ready_o (req_ready_o),
      .v_o     (fifo_v),
      .data_o  (fifo_data),
      .yumi_i  (deq)
   );

   always_ff @(posedge clk_i) begin
      if (reset_i) state_r <= IDLE;
      else         state_r <= state_n;
   end

   // NOTE: default assignment first so no path through the case infers a latch.
   always_comb begin
      state_n = state_r;
      case (state_r)
         IDLE:    if (fifo_v) state_n = PULSE;
         PULSE:   state_n = GAP;
         GAP:     if (gap_r == '0) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      deq      = (state_r == IDLE) && fifo_v;
      gap_load = (state_r == PULSE);
      v_n      = (state_n == PULSE);
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         print_stat_v_o   <= 1'b0;
         print_stat_tag_o <= '0;
         gap_r            <= '0;
         global_ctr_o     <= '0;
         pending_o        <= '0;
      end else begin
         print_stat_v_o <= v_n;
         global_ctr_o   <= global_ctr_o + 1'b1;
         if (deq) print_stat_tag_o <= fifo_data;
         if (gap_load)
            gap_r <= gap_w'(gap_cycles_p - 1);
         else if (state_r == GAP && gap_r != '0)
            gap_r <= gap_r - 1'b1;
         // Simultaneous enqueue and dequeue leaves the occupancy unchanged.
         case ({enq, deq})
            2'b10:   pending_o <= pending_o + 1'b1;
            2'b01:   pending_o <= pending_o - 1'b1;
            default: pending_o <= pending_o;
         endcase
      end
   end

endmodule
